// File: rtl/aemb_dwb_ctrl.sv
// aemb_dwb_ctrl -- AEMB data-bus (DWB) Wishbone master controller.
//
// Decodes load/store opcodes and the ALU effective address into a word
// address, big-endian byte-lane selects and strobes. It runs the Wishbone
// handshake and holds the pipeline until the access is acknowledged, times
// out, or is rejected as misaligned.
//
// Ports:
//   gclk        in   core clock, rising edge
//   grst        in   synchronous active-high reset
//   mem_req     in   execute stage presents a memory instruction
//   rOPC[5:0]   in   opcode ([5:4]=11,[3]=0 memory op; [2] store; [1:0] size)
//   rRESULT     in   effective byte address
//   dwb_ack_i   in   Wishbone ack
//   dwb_adr_o   out  registered word address (rRESULT[31:2])
//   dwb_sel_o   out  registered byte-lane select, big-endian
//   dwb_stb_o   out  registered strobe/cycle
//   dwb_we_o    out  registered write enable
//   rDWBSEL     out  lane select for the register-file load sizer
//   lsu_stall   out  combinational pipeline hold
//   dwb_err     out  one-cycle pulse on misaligned or timed-out access
module aemb_dwb_ctrl #(
  parameter int TOUT = 8
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        mem_req,
  input  logic [5:0]  rOPC,
  input  logic [31:0] rRESULT,
  input  logic        dwb_ack_i,
  output logic [29:0] dwb_adr_o,
  output logic [3:0]  dwb_sel_o,
  output logic        dwb_stb_o,
  output logic        dwb_we_o,
  output logic [3:0]  rDWBSEL,
  output logic        lsu_stall,
  output logic        dwb_err
);

  typedef enum logic {IDLE, BUS} state_t;

  // The counter is cleared when stb rises; stb has then been high for
  // 2^TOUT-1 cycles in the cycle where the counter shows all-ones minus one,
  // so that is the abort cycle (counter reaches all-ones on its edge).
  localparam logic [TOUT-1:0] TOUT_LAST = {{(TOUT-1){1'b1}}, 1'b0};

  state_t          rState;
  logic [TOUT-1:0] rTout;

  logic       memOp;
  logic       laneOk;
  logic [3:0] laneSel;
  logic       reqOk;
  logic       misalign;
  logic       toutLast;

  // Returns {aligned, sel} for a given size and address offset.
  function automatic logic [4:0] laneDecode(input logic [1:0] size,
                                            input logic [1:0] a);
    logic [4:0] r;
    r = 5'b0_0000;
    case (size)
      2'd0: begin
        case (a)
          2'd0: r = 5'b1_1000;
          2'd1: r = 5'b1_0100;
          2'd2: r = 5'b1_0010;
          default: r = 5'b1_0001;
        endcase
      end
      2'd1: begin
        if (a == 2'd0)      r = 5'b1_1100;
        else if (a == 2'd2) r = 5'b1_0011;
      end
      2'd2: begin
        if (a == 2'd0) r = 5'b1_1111;
      end
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    memOp             = mem_req & (rOPC[5:4] == 2'b11) & ~rOPC[3];
    {laneOk, laneSel} = laneDecode(rOPC[1:0], rRESULT[1:0]);
    reqOk             = memOp & laneOk;
    misalign          = memOp & ~laneOk;
    toutLast          = (rTout == TOUT_LAST);
    // In BUS the stall drops on the ack cycle or on the abort cycle.
    if (rState == IDLE) lsu_stall = reqOk;
    else                lsu_stall = ~dwb_ack_i & ~toutLast;
  end

  assign rDWBSEL = dwb_sel_o;

  always_ff @(posedge gclk) begin
    if (grst) begin
      rState    <= IDLE;
      rTout     <= '0;
      dwb_stb_o <= 1'b0;
      dwb_we_o  <= 1'b0;
      dwb_sel_o <= 4'h0;
      dwb_adr_o <= 30'h0;
      dwb_err   <= 1'b0;
    end else begin
      dwb_err <= 1'b0;
      case (rState)
        IDLE: begin
          if (reqOk) begin
            dwb_adr_o <= rRESULT[31:2];
            dwb_sel_o <= laneSel;
            dwb_we_o  <= rOPC[2];
            dwb_stb_o <= 1'b1;
            rTout     <= '0;
            rState    <= BUS;
          end else if (misalign) begin
            dwb_err <= 1'b1;
          end
        end
        BUS: begin
          rTout <= rTout + 1'b1;
          // Ack takes priority over a simultaneous timeout; sel is held
          // so the load sizer stays aligned through writeback.
          if (dwb_ack_i) begin
            dwb_stb_o <= 1'b0;
            dwb_we_o  <= 1'b0;
            rState    <= IDLE;
          end else if (toutLast) begin
            dwb_stb_o <= 1'b0;
            dwb_we_o  <= 1'b0;
            dwb_err   <= 1'b1;
            rState    <= IDLE;
          end
        end
        default: rState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_dwb_ctrl.sv
module tb_aemb_dwb_ctrl;

  localparam int TOUT    = 4;
  localparam int TMAX    = (1 << TOUT) - 1;  // cycles stb stays high before abort

  localparam logic [5:0] LBU = 6'b110000;
  localparam logic [5:0] LW  = 6'b110010;
  localparam logic [5:0] SH  = 6'b110101;
  localparam logic [5:0] SW  = 6'b110110;

  logic        gclk = 1'b0;
  logic        grst = 1'b0;
  logic        mem_req = 1'b0;
  logic [5:0]  rOPC = 6'h0;
  logic [31:0] rRESULT = 32'h0;
  logic        dwb_ack_i = 1'b0;
  logic [29:0] dwb_adr_o;
  logic [3:0]  dwb_sel_o;
  logic        dwb_stb_o;
  logic        dwb_we_o;
  logic [3:0]  rDWBSEL;
  logic        lsu_stall;
  logic        dwb_err;

  int vectors = 0;
  int errors  = 0;
  logic [3:0] lastSel = 4'h0;

  aemb_dwb_ctrl #(.TOUT(TOUT)) dut (
    .gclk(gclk), .grst(grst), .mem_req(mem_req), .rOPC(rOPC),
    .rRESULT(rRESULT), .dwb_ack_i(dwb_ack_i), .dwb_adr_o(dwb_adr_o),
    .dwb_sel_o(dwb_sel_o), .dwb_stb_o(dwb_stb_o), .dwb_we_o(dwb_we_o),
    .rDWBSEL(rDWBSEL), .lsu_stall(lsu_stall), .dwb_err(dwb_err)
  );

  always #5 gclk = ~gclk;

  // One memory instruction: request cycle, bus cycles with an ack after
  // 'waits' wait states, then (optionally) two idle cycles checking err.
  task automatic do_access(input string tag, input logic [5:0] opc,
                           input logic [31:0] addr, input int waits,
                           input bit post);
    bit isMem, ok, expErr, done;
    logic [3:0] es;
    logic expReq;
    int stbN, stallN, expCyc;
    isMem = (opc[5:4] == 2'b11) && !opc[3];
    ok = 1'b0; es = 4'h0;
    case (opc[1:0])
      2'd0: begin es = 4'b1000 >> addr[1:0]; ok = 1'b1; end
      2'd1: if (!addr[0]) begin es = addr[1] ? 4'h3 : 4'hC; ok = 1'b1; end
      2'd2: if (addr[1:0] == 2'd0) begin es = 4'hF; ok = 1'b1; end
      default: ;
    endcase
    expReq = isMem && ok;
    expErr = isMem && !ok;

    @(negedge gclk);
    mem_req = 1'b1; rOPC = opc; rRESULT = addr; dwb_ack_i = 1'b0;
    #1;
    vectors++;
    if (lsu_stall !== expReq) begin
      errors++; $display("FAIL %s req_stall: got %b expected %b", tag, lsu_stall, expReq);
    end
    vectors++;
    if (dwb_stb_o !== 1'b0) begin
      errors++; $display("FAIL %s req_stb_low: got %b expected 0", tag, dwb_stb_o);
    end
    stallN = (lsu_stall === 1'b1) ? 1 : 0;
    @(posedge gclk);

    if (expReq) begin
      stbN = 0; done = 1'b0;
      for (int k = 1; k <= 40 && !done; k++) begin
        @(negedge gclk);
        mem_req = 1'b0;
        dwb_ack_i = (k == waits + 1);
        #1;
        if (dwb_stb_o === 1'b1) stbN++;
        if (lsu_stall === 1'b1) stallN++;
        if (k == 1) begin
          vectors++;
          if (dwb_adr_o !== addr[31:2] || dwb_sel_o !== es || rDWBSEL !== es || dwb_we_o !== opc[2]) begin
            errors++;
            $display("FAIL %s bus_fields: got adr=%h sel=%h rsel=%h we=%b expected adr=%h sel=%h we=%b",
                     tag, dwb_adr_o, dwb_sel_o, rDWBSEL, dwb_we_o, addr[31:2], es, opc[2]);
          end
        end
        if (dwb_ack_i || lsu_stall !== 1'b1) done = 1'b1;
        @(posedge gclk);
      end
      if (waits + 1 <= TMAX) expCyc = waits + 1;
      else begin expCyc = TMAX; expErr = 1'b1; end
      vectors++;
      if (stbN !== expCyc) begin
        errors++; $display("FAIL %s stb_cycles: got %0d expected %0d", tag, stbN, expCyc);
      end
      vectors++;
      if (stallN !== expCyc) begin
        errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stallN, expCyc);
      end
      lastSel = es;
    end

    if (post) begin
      @(negedge gclk);
      mem_req = 1'b0; dwb_ack_i = 1'b0;
      #1;
      vectors++;
      if (dwb_err !== expErr || dwb_stb_o !== 1'b0 || lsu_stall !== 1'b0 ||
          dwb_sel_o !== lastSel || rDWBSEL !== lastSel) begin
        errors++;
        $display("FAIL %s after: got err=%b stb=%b stall=%b sel=%h rsel=%h expected err=%b stb=0 stall=0 sel=%h",
                 tag, dwb_err, dwb_stb_o, lsu_stall, dwb_sel_o, rDWBSEL, expErr, lastSel);
      end
      @(posedge gclk);
      @(negedge gclk);
      #1;
      vectors++;
      if (dwb_err !== 1'b0) begin
        errors++; $display("FAIL %s err_pulse_width: got %b expected 0", tag, dwb_err);
      end
      @(posedge gclk);
    end
  endtask

  task automatic test_reset();
    @(negedge gclk);
    grst = 1'b1; mem_req = 1'b0; dwb_ack_i = 1'b0;
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    grst = 1'b0;
    #1;
    vectors++;
    if (dwb_stb_o !== 1'b0 || dwb_we_o !== 1'b0 || dwb_sel_o !== 4'h0 || rDWBSEL !== 4'h0 ||
        dwb_adr_o !== 30'h0 || dwb_err !== 1'b0 || lsu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset: got stb=%b we=%b sel=%h rsel=%h adr=%h err=%b stall=%b expected all 0",
               dwb_stb_o, dwb_we_o, dwb_sel_o, rDWBSEL, dwb_adr_o, dwb_err, lsu_stall);
    end
    lastSel = 4'h0;
    @(posedge gclk);
  endtask

  task automatic test_lbu_wait();
    do_access("lbu_wait2", LBU, 32'h0000_1003, 2, 1'b1);
  endtask

  task automatic test_sh_zero_wait();
    do_access("sh_zero_wait", SH, 32'h0000_2002, 0, 1'b1);
  endtask

  task automatic test_lw_misaligned();
    do_access("lw_misaligned", LW, 32'h0000_0006, 0, 1'b1);
  endtask

  task automatic test_sw_timeout();
    do_access("sw_timeout", SW, 32'h0000_0010, 100, 1'b1);
  endtask

  task automatic test_ack_timeout_tie();
    do_access("ack_timeout_tie", LW, 32'h0000_0040, TMAX - 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_access("b2b_first", LBU, 32'h0000_0000, 0, 1'b0);
    do_access("b2b_second", LBU, 32'h0000_0001, 0, 1'b1);
  endtask

  task automatic test_spurious_ack();
    @(negedge gclk);
    mem_req = 1'b0; dwb_ack_i = 1'b1;
    #1;
    vectors++;
    if (lsu_stall !== 1'b0) begin
      errors++; $display("FAIL spurious_ack_stall: got %b expected 0", lsu_stall);
    end
    @(posedge gclk);
    @(negedge gclk);
    dwb_ack_i = 1'b0;
    #1;
    vectors++;
    if (dwb_stb_o !== 1'b0 || dwb_err !== 1'b0 || dwb_sel_o !== lastSel) begin
      errors++;
      $display("FAIL spurious_ack_state: got stb=%b err=%b sel=%h expected stb=0 err=0 sel=%h",
               dwb_stb_o, dwb_err, dwb_sel_o, lastSel);
    end
    @(posedge gclk);
  endtask

  task automatic test_reset_mid_access();
    @(negedge gclk);
    mem_req = 1'b1; rOPC = SW; rRESULT = 32'h0000_0020; dwb_ack_i = 1'b0;
    @(posedge gclk);
    @(negedge gclk);
    mem_req = 1'b0;
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    #1;
    vectors++;
    if (dwb_stb_o !== 1'b1 || lsu_stall !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: got stb=%b stall=%b expected 1 1", dwb_stb_o, lsu_stall);
    end
    grst = 1'b1;
    @(posedge gclk);
    @(negedge gclk);
    grst = 1'b0;
    #1;
    vectors++;
    if (dwb_stb_o !== 1'b0 || dwb_sel_o !== 4'h0 || dwb_err !== 1'b0 || lsu_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_post: got stb=%b sel=%h err=%b stall=%b expected 0 0 0 0",
               dwb_stb_o, dwb_sel_o, dwb_err, lsu_stall);
    end
    lastSel = 4'h0;
    @(posedge gclk);
    @(negedge gclk);
    #1;
    vectors++;
    if (dwb_err !== 1'b0 || dwb_stb_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_later: got err=%b stb=%b expected 0 0", dwb_err, dwb_stb_o);
    end
    @(posedge gclk);
  endtask

  task automatic test_random();
    logic [5:0] opc;
    logic [31:0] addr;
    int waits;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) opc = 6'($urandom);
      else opc = {3'b110, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      addr = $urandom;
      if ($urandom_range(0, 7) == 0) waits = $urandom_range(TMAX - 2, TMAX + 4);
      else waits = $urandom_range(0, 5);
      do_access("random", opc, addr, waits, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_lbu_wait();
    test_sh_zero_wait();
    test_lw_misaligned();
    test_sw_timeout();
    test_ack_timeout_tie();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/aemb_dwb_ctrl.md
# aemb_dwb_ctrl

Data-bus (DWB) Wishbone master controller for the AEMB core. It sits between the execute stage and the external data bus, downstream of the register file's store sizer (`dwb_dat_o`) and upstream of its load sizer (`dwb_dat_i` / `rDWBSEL`). It decodes load/store opcodes and the effective address into word address, byte-lane selects and strobes. It runs the Wishbone handshake and stalls the pipeline until the access completes, is aborted on timeout, or is rejected as misaligned.

## Interface
- `TOUT`, default 8, width of the bus-timeout counter. An access aborts after 2^TOUT−1 cycles without an ack.
- `gclk` in 1: core clock. All state changes on the rising edge.
- `grst` in 1: reset. Synchronous, active-high.
- `mem_req` in 1: execute stage presents a memory instruction this cycle.
- `rOPC` in 6: opcode. Decoding:
  - `[5:4]=2'b11` with `[3]=0` marks a memory op.
  - `[2]` marks a store.
  - `[1:0]` gives the size: 0 byte, 1 half, 2 word, 3 illegal.
- `rRESULT` in 32: effective byte address from the ALU.
- `dwb_ack_i` in 1: Wishbone ack.
- `dwb_adr_o` out 30: word address, `rRESULT[31:2]`, registered.
- `dwb_sel_o` out 4: byte-lane select, big-endian, registered.
- `dwb_stb_o` out 1: strobe/cycle, registered.
- `dwb_we_o` out 1: write enable, registered.
- `rDWBSEL` out 4: lane select fed to the register-file load sizer. Equals `dwb_sel_o`.
- `lsu_stall` out 1: pipeline hold, combinational. The core forms `gena = ~lsu_stall & …`.
- `dwb_err` out 1: one-cycle pulse on a misaligned or timed-out access.

## Operation
- Accept condition: `mem_req & rOPC[5:4]==3 & ~rOPC[3]`. A non-memory opcode with `mem_req` high is ignored.
- Lane encoding, with `a = rRESULT[1:0]`:
  - Byte: a=0→8, 1→4, 2→2, 3→1.
  - Half: a=0→C, a=2→3.
  - Word: a=0→F.
  - Anything else (half with a odd, word with a≠0, size 3) is misaligned.
- Misaligned access:
  - No bus cycle is issued.
  - `dwb_err` pulses on the next edge.
  - The FSM stays in IDLE.
  - `lsu_stall` is 0.
- State machine with states IDLE and BUS:
  - **IDLE:**
    - On an accepted, aligned request, register adr, sel, we=`rOPC[2]`, and stb=1. Go to BUS and clear the timeout counter.
    - `lsu_stall` = 1 in the request cycle.
  - **BUS:**
    - `lsu_stall` = `~dwb_ack_i`.
    - On ack, go to IDLE: stb and we clear on that edge, and sel/`rDWBSEL` are held until the next access.
    - Without ack, the counter increments. When the counter reaches all-ones, abort: stb=0, `dwb_err` pulse, go to IDLE, and release the stall that cycle.
- `rDWBSEL` remains stable through the ack cycle so the load sizer aligns `dwb_dat_i` while the writeback stage captures it.
- Store data is supplied by the register file on `dwb_dat_o`. It is registered on the same gena-qualified edge that sets stb, so it is valid whenever stb=1.
- `mem_req` arriving while in BUS is ignored. The pipeline is stalled, so the instruction is re-presented.

## Timing
- Reset values: `dwb_stb_o`=0, `dwb_we_o`=0, `dwb_sel_o`=0, `rDWBSEL`=0, `dwb_adr_o`=0, `dwb_err`=0, state IDLE, counter 0. `lsu_stall`=0 after reset.
- Request in cycle N → stb high from N+1.
- Ack at cycle N+k (k≥1) → `lsu_stall` low in cycle N+k, stb low from N+k+1.
- Minimum access: 2 cycles stalled-or-active. A zero-wait slave acks in N+1, giving 1 stall cycle (N).
- Back-to-back accesses: a new request can be accepted the cycle after ack, because the FSM is in IDLE again. stb has at least one low cycle between accesses.
- Ack seen in IDLE (spurious) is ignored.
- Ack and timeout in the same cycle: the ack wins, and no err is raised.
- `grst` asserted mid-access: stb drops on that edge, with no err pulse. The slave must tolerate the abandoned cycle.

## Test plan
- LBU, addr 0x1003, ack after 2 wait cycles:
  - adr=0x400, sel=1, we=0.
  - stb high 3 cycles.
  - `lsu_stall` high 3 cycles, low on the ack cycle.
  - `rDWBSEL`=1 held after.
- SH, addr 0x2002, zero-wait ack: sel=3, we=1, one stall cycle, stb high exactly one cycle.
- LW, addr 0x0006: misaligned, so no stb, `dwb_err`=1 for one cycle, `lsu_stall`=0 throughout.
- SW, addr 0x10, no ack, TOUT=4:
  - stb high 15 cycles, then drops.
  - `dwb_err` pulse.
  - Stall released in the abort cycle.
- Two LBU back-to-back with zero-wait acks: sel 8 then 4, with stb low for one cycle between them.
- `grst` asserted during a BUS wait: stb=0, sel=0, and state IDLE on the next cycle, with no err pulse.
